debug_command: RTL and testbench

Abstract-command engine of the debug module. It accepts RISC-V debug-spec `command` writes from the DMI register file and owns the `data0`/`data1` registers. It sequences each command into the halted core's abstract interface and drives `abstract`, opcode, funct3 and operands. It then tracks the core's `abstract_write`, `abstract_done`, `exception` and `halted` responses to report `busy` and `cmderr`.

---
 rtl/debug_command.sv | 158 +++++++++++++++
 tb/tb_debug_command.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_command.sv
// debug_command: abstract-command engine. Decodes DMI command writes, owns data0/data1,
// sequences register/memory/exec requests into the halted core and reports busy/cmderr.
module debug_command (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_wr,
  input  logic        data0_wr,
  input  logic        data1_wr,
  input  logic [31:0] dmi_wdata,
  input  logic [2:0]  cmderr_clr,
  output logic [31:0] data0,
  output logic [31:0] data1,
  output logic        busy,
  output logic [2:0]  cmderr,
  input  logic        halted,
  input  logic        exception,
  input  logic        abstract_write,
  input  logic        abstract_done,
  input  logic [31:0] abs_rdata,
  output logic        abstract,
  output logic [4:0]  abs_opcode,
  output logic [2:0]  abs_f3,
  output logic [11:0] abs_regno,
  output logic [31:0] abs_data,
  output logic [31:0] abs_addr,
  output logic [1:0]  abs_size
);

  localparam logic [4:0] OP_ACCESS_REG = 5'd0;
  localparam logic [4:0] OP_EXEC       = 5'd1;
  localparam logic [4:0] OP_READ_MEM   = 5'd2;
  localparam logic [4:0] OP_WRITE_MEM  = 5'd3;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EXEC, S_RECOVER} state_t;
  state_t state, state_nxt;

  logic [7:0]  c_type;
  logic [2:0]  c_size;
  logic        c_postinc, c_postexec, c_transfer, c_write;
  logic [15:0] c_regno;
  logic        is_reg, is_mem, is_nop, unsupported;
  logic        cmd_go, accept, resp_phase, exc, done_ev, capture;
  logic        cur_postinc, cur_postexec, cur_mem, seen_run;
  logic [15:0] cur_regno;
  logic        busy_nxt;
  logic [2:0]  cmderr_nxt;
  logic        unused_bits;

  assign c_type      = dmi_wdata[31:24];
  assign c_size      = dmi_wdata[22:20];
  assign c_postinc   = dmi_wdata[19];
  assign c_postexec  = dmi_wdata[18];
  assign c_transfer  = dmi_wdata[17];
  assign c_write     = dmi_wdata[16];
  assign c_regno     = dmi_wdata[15:0];
  assign unused_bits = dmi_wdata[23];

  assign is_reg = (c_type == 8'd0);
  assign is_mem = (c_type == 8'd2);
  assign is_nop = is_reg && !c_transfer && !c_postexec;
  // CSR (0x0000-0x0FFF) and GPR (0x1000-0x101F) windows are contiguous
  assign unsupported = !(is_reg || is_mem)
                    || (is_reg && c_size != 3'd2)
                    || (is_reg && c_transfer && c_regno > 16'h101F)
                    || (is_mem && c_size > 3'd2);

  assign cmd_go     = cmd_wr && (cmderr == 3'd0) && !busy;
  assign accept     = cmd_go && halted && !unsupported;
  assign resp_phase = (state == S_ISSUE) || (state == S_WAIT);
  assign exc        = exception && (resp_phase || state == S_EXEC);
  assign capture    = resp_phase && abstract_write;
  // postexec requests only complete from WAIT so the core sees a full issue cycle
  assign done_ev    = abstract_done && !exception
                   && ((state == S_ISSUE && !cur_postexec) || state == S_WAIT);
  assign abstract   = (state == S_ISSUE) && halted;

  always_comb begin
    state_nxt  = state;
    cmderr_nxt = cmderr & ~cmderr_clr;
    case (state)
      S_IDLE:          if (accept && !is_nop) state_nxt = S_ISSUE;
      S_ISSUE, S_WAIT: begin
        if (exc)                   state_nxt = S_RECOVER;
        else if (done_ev)          state_nxt = cur_postexec ? S_EXEC : S_IDLE;
        else if (state == S_ISSUE) state_nxt = S_WAIT;
      end
      S_EXEC: begin
        if (exc)                     state_nxt = S_RECOVER;
        else if (seen_run && halted) state_nxt = S_IDLE;
      end
      S_RECOVER:       if (halted) state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase
    if (cmderr == 3'd0) begin
      if (exc)                               cmderr_nxt = 3'd3;
      else if (cmd_wr && busy)               cmderr_nxt = 3'd1;
      else if ((data0_wr || data1_wr) && busy) cmderr_nxt = 3'd1;
      else if (cmd_go && !halted)            cmderr_nxt = 3'd4;
      else if (cmd_go && unsupported)        cmderr_nxt = 3'd2;
    end
    busy_nxt = (state_nxt != S_IDLE) || accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      cmderr       <= 3'd0;
      data0        <= 32'd0;
      data1        <= 32'd0;
      abs_opcode   <= 5'd0;
      abs_f3       <= 3'd0;
      abs_regno    <= 12'd0;
      abs_data     <= 32'd0;
      abs_addr     <= 32'd0;
      abs_size     <= 2'd0;
      cur_regno    <= 16'd0;
      cur_postinc  <= 1'b0;
      cur_postexec <= 1'b0;
      cur_mem      <= 1'b0;
      seen_run     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      cmderr <= cmderr_nxt;

      if (capture)                data0 <= abs_rdata;
      else if (data0_wr && !busy) data0 <= dmi_wdata;

      if (done_ev && cur_postinc && cur_mem) data1 <= data1 + (32'd1 << abs_size);
      else if (data1_wr && !busy)            data1 <= dmi_wdata;

      if (state != S_EXEC) seen_run <= 1'b0;
      else if (!halted)    seen_run <= 1'b1;

      if (accept) begin
        if (is_mem)          abs_opcode <= c_write ? OP_WRITE_MEM : OP_READ_MEM;
        else if (c_transfer) abs_opcode <= OP_ACCESS_REG;
        else                 abs_opcode <= OP_EXEC;
        if (is_mem)          abs_f3 <= {c_write, 2'b00};
        else if (c_transfer) abs_f3 <= {c_write, (c_regno < 16'h1000), c_postexec};
        else                 abs_f3 <= 3'b001;
        abs_regno    <= is_reg ? c_regno[11:0] : 12'd0;
        abs_data     <= data0;
        abs_addr     <= data1;
        abs_size     <= c_size[1:0];
        cur_regno    <= c_regno;
        cur_postinc  <= c_postinc && (is_mem || c_transfer);
        cur_postexec <= is_reg && c_postexec;
        cur_mem      <= is_mem;
      end else if (done_ev && cur_postinc && !cur_mem) begin
        cur_regno <= cur_regno + 16'd1;
        abs_regno <= cur_regno[11:0] + 12'd1;
      end
    end
  end

endmodule

// File: tb/tb_debug_command.sv
// Directed bench for debug_command with a small combinational core responder.
module tb_debug_command;

  logic        clk;
  logic        rst_n, cmd_wr, data0_wr, data1_wr;
  logic [31:0] dmi_wdata;
  logic [2:0]  cmderr_clr;
  logic [31:0] data0, data1;
  logic        busy;
  logic [2:0]  cmderr;
  logic        halted, exception, abstract_write, abstract_done;
  logic [31:0] abs_rdata;
  logic        abstract;
  logic [4:0]  abs_opcode;
  logic [2:0]  abs_f3;
  logic [11:0] abs_regno;
  logic [31:0] abs_data, abs_addr;
  logic [1:0]  abs_size;
  logic        auto_done, auto_write, man_done, man_write;
  int          n_cmp = 0;
  int          n_bad = 0;

  // core answers in the issue cycle when auto_* is set, otherwise when man_* is driven
  assign abstract_done  = (auto_done & abstract) | man_done;
  assign abstract_write = (auto_write & abstract) | man_write;

  debug_command dut (
    .clk(clk), .rst_n(rst_n), .cmd_wr(cmd_wr), .data0_wr(data0_wr), .data1_wr(data1_wr),
    .dmi_wdata(dmi_wdata), .cmderr_clr(cmderr_clr), .data0(data0), .data1(data1),
    .busy(busy), .cmderr(cmderr), .halted(halted), .exception(exception),
    .abstract_write(abstract_write), .abstract_done(abstract_done), .abs_rdata(abs_rdata),
    .abstract(abstract), .abs_opcode(abs_opcode), .abs_f3(abs_f3), .abs_regno(abs_regno),
    .abs_data(abs_data), .abs_addr(abs_addr), .abs_size(abs_size)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [31:0] w);
    cmd_wr = 1'b1; dmi_wdata = w;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic clear_err(input logic [2:0] m);
    cmderr_clr = m;
    tick();
    cmderr_clr = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_wr = 0; data0_wr = 0; data1_wr = 0; dmi_wdata = 0; cmderr_clr = 0;
    halted = 1'b1; exception = 0; abs_rdata = 0;
    auto_done = 0; auto_write = 0; man_done = 0; man_write = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL reset_cmderr: got %h want 0", cmderr); end
    n_cmp++; if (data0 !== 32'd0) begin n_bad++; $display("FAIL reset_data0: got %h want 0", data0); end
    n_cmp++; if (data1 !== 32'd0) begin n_bad++; $display("FAIL reset_data1: got %h want 0", data1); end
    n_cmp++; if (abstract !== 1'b0) begin n_bad++; $display("FAIL reset_abstract: got %h want 0", abstract); end
    n_cmp++; if ({abs_opcode, abs_f3, abs_regno, abs_size} !== 22'd0) begin n_bad++;
      $display("FAIL reset_abs_fields: got %h want 0", {abs_opcode, abs_f3, abs_regno, abs_size}); end
    n_cmp++; if ({abs_data, abs_addr} !== 64'd0) begin n_bad++;
      $display("FAIL reset_abs_data_addr: got %h want 0", {abs_data, abs_addr}); end
  endtask

  task automatic test_gpr_write();
    data0_wr = 1'b1; dmi_wdata = 32'hDEADBEEF;
    tick();
    data0_wr = 1'b0;
    n_cmp++; if (data0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL gpr_data0_wr: got %h want deadbeef", data0); end
    auto_done = 1'b1;
    issue_cmd(32'h00231005);
    n_cmp++; if (abstract !== 1'b1) begin n_bad++; $display("FAIL gpr_abstract: got %h want 1", abstract); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL gpr_busy_n1: got %h want 1", busy); end
    n_cmp++; if (abs_opcode !== 5'd0) begin n_bad++; $display("FAIL gpr_opcode: got %h want 0", abs_opcode); end
    n_cmp++; if (abs_f3 !== 3'b100) begin n_bad++; $display("FAIL gpr_f3: got %b want 100", abs_f3); end
    n_cmp++; if (abs_regno !== 12'h005) begin n_bad++; $display("FAIL gpr_regno: got %h want 005", abs_regno); end
    n_cmp++; if (abs_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL gpr_abs_data: got %h want deadbeef", abs_data); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gpr_busy_n2: got %h want 0", busy); end
    n_cmp++; if (abstract !== 1'b0) begin n_bad++; $display("FAIL gpr_abstract_n2: got %h want 0", abstract); end
    auto_done = 1'b0;
  endtask

  task automatic test_csr_read();
    auto_done = 1'b1; auto_write = 1'b1; abs_rdata = 32'h00001888;
    issue_cmd(32'h002A0300);
    n_cmp++; if (abs_f3 !== 3'b010) begin n_bad++; $display("FAIL csr_f3: got %b want 010", abs_f3); end
    n_cmp++; if (abs_regno !== 12'h300) begin n_bad++; $display("FAIL csr_regno: got %h want 300", abs_regno); end
    tick();
    auto_done = 1'b0; auto_write = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL csr_busy: got %h want 0", busy); end
    n_cmp++; if (data0 !== 32'h00001888) begin n_bad++; $display("FAIL csr_data0: got %h want 00001888", data0); end
    n_cmp++; if (abs_regno !== 12'h301) begin n_bad++; $display("FAIL csr_postinc: got %h want 301", abs_regno); end
    n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL csr_cmderr: got %h want 0", cmderr); end
  endtask

  task automatic test_mem_read();
    data1_wr = 1'b1; dmi_wdata = 32'hFFFFFFFC;
    tick();
    data1_wr = 1'b0;
    n_cmp++; if (data1 !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL mem_data1_wr: got %h want fffffffc", data1); end
    issue_cmd(32'h02280000);
    n_cmp++; if (abstract !== 1'b1) begin n_bad++; $display("FAIL mem_abstract: got %h want 1", abstract); end
    n_cmp++; if (abs_opcode !== 5'd2) begin n_bad++; $display("FAIL mem_opcode: got %h want 2", abs_opcode); end
    n_cmp++; if (abs_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL mem_addr: got %h want fffffffc", abs_addr); end
    n_cmp++; if (abs_size !== 2'd2) begin n_bad++; $display("FAIL mem_size: got %h want 2", abs_size); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({busy, abstract} !== 2'b10) begin n_bad++;
        $display("FAIL mem_wait%0d busy/abstract: got %b want 10", i, {busy, abstract}); end
    end
    man_done = 1'b1; man_write = 1'b1; abs_rdata = 32'h12345678;
    tick();
    man_done = 1'b0; man_write = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mem_busy: got %h want 0", busy); end
    n_cmp++; if (data0 !== 32'h12345678) begin n_bad++; $display("FAIL mem_data0: got %h want 12345678", data0); end
    n_cmp++; if (data1 !== 32'h00000000) begin n_bad++; $display("FAIL mem_postinc_wrap: got %h want 0", data1); end
  endtask

  task automatic test_nop();
    issue_cmd(32'h00200000);
    n_cmp++; if ({busy, abstract} !== 2'b10) begin n_bad++;
      $display("FAIL nop_pulse busy/abstract: got %b want 10", {busy, abstract}); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nop_busy_end: got %h want 0", busy); end
  endtask

  task automatic test_busy_err();
    issue_cmd(32'h02200000);
    issue_cmd(32'h00231005);
    n_cmp++; if (cmderr !== 3'd1) begin n_bad++; $display("FAIL busy_cmderr: got %h want 1", cmderr); end
    data0_wr = 1'b1; dmi_wdata = 32'hA5A5A5A5;
    tick();
    data0_wr = 1'b0;
    n_cmp++; if (data0 !== 32'h12345678) begin n_bad++; $display("FAIL busy_data0_drop: got %h want 12345678", data0); end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_complete: got %h want 0", busy); end
    auto_done = 1'b1;
    issue_cmd(32'h00231005);
    n_cmp++; if ({busy, abstract, cmderr} !== 5'b00001) begin n_bad++;
      $display("FAIL busy_ignored busy/abstract/cmderr: got %b want 00001", {busy, abstract, cmderr}); end
    tick();
    clear_err(3'b001);
    n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL busy_clr: got %h want 0", cmderr); end
    issue_cmd(32'h00231005);
    n_cmp++; if (abstract !== 1'b1) begin n_bad++; $display("FAIL busy_after_clr: got %h want 1", abstract); end
    n_cmp++; if (abs_data !== 32'h12345678) begin n_bad++; $display("FAIL busy_abs_data: got %h want 12345678", abs_data); end
    tick();
    auto_done = 1'b0;
  endtask

  task automatic test_errors();
    halted = 1'b0;
    issue_cmd(32'h00231005);
    n_cmp++; if (cmderr !== 3'd4) begin n_bad++; $display("FAIL running_cmderr: got %h want 4", cmderr); end
    n_cmp++; if ({busy, abstract} !== 2'b00) begin n_bad++;
      $display("FAIL running_no_issue busy/abstract: got %b want 00", {busy, abstract}); end
    halted = 1'b1;
    clear_err(3'b100);
    n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL running_clr: got %h want 0", cmderr); end
    issue_cmd(32'h00331005);
    n_cmp++; if ({busy, cmderr} !== 4'b0010) begin n_bad++;
      $display("FAIL aarsize3 busy/cmderr: got %b want 0010", {busy, cmderr}); end
    clear_err(3'b010);
    issue_cmd(32'h00231020);
    n_cmp++; if (cmderr !== 3'd2) begin n_bad++; $display("FAIL gpr_1020: got %h want 2", cmderr); end
    clear_err(3'b010);
    issue_cmd(32'h02300000);
    n_cmp++; if (cmderr !== 3'd2) begin n_bad++; $display("FAIL aamsize3: got %h want 2", cmderr); end
    clear_err(3'b010);
    auto_done = 1'b1;
    issue_cmd(32'h0023101F);
    n_cmp++; if ({abstract, abs_regno} !== 13'h101F) begin n_bad++;
      $display("FAIL gpr_101f abstract/regno: got %h want 101f", {abstract, abs_regno}); end
    tick();
    auto_done = 1'b0;
  endtask

  task automatic test_postexec_exc();
    issue_cmd(32'h00271005);
    n_cmp++; if ({abstract, abs_f3} !== 4'b1101) begin n_bad++;
      $display("FAIL pexec_issue abstract/f3: got %b want 1101", {abstract, abs_f3}); end
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    halted = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pexec_exec_busy: got %h want 1", busy); end
    exception = 1'b1;
    tick();
    exception = 1'b0;
    n_cmp++; if (cmderr !== 3'd3) begin n_bad++; $display("FAIL pexec_cmderr: got %h want 3", cmderr); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pexec_recover_busy: got %h want 1", busy); end
    halted = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pexec_recover_done: got %h want 0", busy); end
    clear_err(3'b011);
    n_cmp++; if (cmderr !== 3'd0) begin n_bad++; $display("FAIL pexec_clr: got %h want 0", cmderr); end
  endtask

  task automatic test_reset_mid();
    issue_cmd(32'h02200000);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if ({busy, abstract} !== 2'b00) begin n_bad++;
      $display("FAIL midreset busy/abstract: got %b want 00", {busy, abstract}); end
    n_cmp++; if (data0 !== 32'd0) begin n_bad++; $display("FAIL midreset_data0: got %h want 0", data0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_csr_read();
    test_mem_read();
    test_nop();
    test_busy_err();
    test_errors();
    test_postexec_exc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
